// File: rtl/btn_mode_debouncer.sv
// btn_mode_debouncer: synchronise and debounce the mode button, emit press/release/long strobes, track display mode
module btn_mode_debouncer #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int LONG_CYCLES     = 3000,
    parameter int NUM_MODES       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [2:0] mode_sel
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [2:0] M_LAST = 3'(NUM_MODES - 1);
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_evt_q, long_evt_d;
    logic          long_done_q, long_done_d;
    logic          btn_level_q, btn_level_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          long_press_q, long_press_d;
    logic [2:0]    mode_q, mode_d;
    logic          s;
    logic          held_any;

    assign s        = sync_q[1];
    assign held_any = state_q == HELD || state_q == RELEASE_CHK;

    // debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES matching samples
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: if (s) begin
                state_d = PRESS_CHK;
                dcnt_d  = DW'(1);
            end
            PRESS_CHK: if (!s) begin
                state_d = IDLE;
                dcnt_d  = '0;
            end else if (dcnt_q == D_LAST) begin
                state_d = HELD;
                dcnt_d  = '0;
            end else dcnt_d = dcnt_q + DW'(1);
            HELD: begin
                hcnt_d = hcnt_q == H_LAST ? hcnt_q : hcnt_q + HW'(1);
                if (!s) begin
                    state_d = RELEASE_CHK;
                    dcnt_d  = DW'(1);
                end
            end
            default: if (s) begin
                state_d = HELD;
                dcnt_d  = '0;
            end else if (dcnt_q == D_LAST) begin
                state_d = IDLE;
                dcnt_d  = '0;
                hcnt_d  = '0;
            end else dcnt_d = dcnt_q + DW'(1);
        endcase
    end

    // registered outputs derived from the accepted level; long_press fires once per accepted press
    always_comb begin
        sync_d          = {sync_q[0], btn_sel};
        long_evt_d      = held_any && hcnt_q == H_LAST && !long_done_q;
        long_done_d     = state_d == IDLE ? 1'b0 : long_done_q | long_evt_d;
        btn_level_d     = held_any;
        press_pulse_d   = held_any && !btn_level_q;
        release_pulse_d = !held_any && btn_level_q;
        long_press_d    = long_evt_q;
        mode_d          = long_press_q ? 3'd0 : press_pulse_q ? (mode_q == M_LAST ? 3'd0 : mode_q + 3'd1) : mode_q;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q          <= '0;
            state_q         <= IDLE;
            dcnt_q          <= '0;
            hcnt_q          <= '0;
            long_evt_q      <= 1'b0;
            long_done_q     <= 1'b0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
            mode_q          <= '0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            dcnt_q          <= dcnt_d;
            hcnt_q          <= hcnt_d;
            long_evt_q      <= long_evt_d;
            long_done_q     <= long_done_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
            mode_q          <= mode_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_press    = long_press_q;
    assign mode_sel      = mode_q;
endmodule

// File: tb/tb_btn_mode_debouncer.sv
// tb_btn_mode_debouncer: table vectors and directed corners on defaults, randomized model check on a small-parameter copy
module tb_btn_mode_debouncer;
    localparam int SD = 4;
    localparam int SL = 20;
    localparam int SN = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, btn_sel = 1'b0;
    logic       lvl, pp, rp, lp;
    logic [2:0] mode;
    logic       sreset = 1'b1, sbtn = 1'b0;
    logic       s_lvl, s_pp, s_rp, s_lp;
    logic [2:0] s_mode;

    btn_mode_debouncer dut (
        .clk(clk), .reset(reset), .btn_sel(btn_sel), .btn_level(lvl),
        .press_pulse(pp), .release_pulse(rp), .long_press(lp), .mode_sel(mode)
    );
    btn_mode_debouncer #(.DEBOUNCE_CYCLES(SD), .LONG_CYCLES(SL), .NUM_MODES(SN)) sdut (
        .clk(clk), .reset(sreset), .btn_sel(sbtn), .btn_level(s_lvl),
        .press_pulse(s_pp), .release_pulse(s_rp), .long_press(s_lp), .mode_sel(s_mode)
    );

    int cmps = 0, errs = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    logic s_done = 1'b0;

    typedef struct {
        int hi;
        int lo;
        int press;
        int rel;
        int lng;
        int mode;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        cmps++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        btn_sel = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_for(input int which, input int bound, output int k);
        k = bound;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((which == 0 && pp) || (which == 1 && rp) || (which == 2 && lp)) begin
                k = i;
                break;
            end
        end
    endtask

    // pulse counters for the default-parameter instance
    always @(negedge clk) begin
        n_press += int'(pp);
        n_rel   += int'(rp);
        n_long  += int'(lp);
    end

    // reference model: accept a level after SD consecutive opposite samples; outputs lag acceptance by one edge
    logic       m_h1, m_h2, m_acc, m_done, m_pp, m_pr, m_pl;
    int         m_run, m_hold;
    logic       e_lvl, e_press, e_rel, e_long;
    logic [2:0] e_mode;
    always @(posedge clk) begin
        logic sv, np, nr, nl;
        if (sreset) begin
            {m_h1, m_h2, m_acc, m_done, m_pp, m_pr, m_pl} = '0;
            {e_lvl, e_press, e_rel, e_long} = '0;
            e_mode = '0;
            m_run = 0;
            m_hold = 0;
        end else begin
            sv = m_h2;
            m_h2 = m_h1;
            m_h1 = sbtn;
            if (e_long) e_mode = 3'd0;
            else if (e_press) e_mode = e_mode == 3'(SN - 1) ? 3'd0 : e_mode + 3'd1;
            e_lvl = m_acc;
            e_press = m_pp;
            e_rel = m_pr;
            e_long = m_pl;
            nl = m_acc && m_hold == SL - 1 && !m_done;
            if (nl) m_done = 1'b1;
            if (m_acc && m_run == 0 && m_hold < SL - 1) m_hold++;
            np = 1'b0;
            nr = 1'b0;
            if (sv != m_acc) begin
                m_run++;
                if (m_run == SD) begin
                    m_acc = sv;
                    m_run = 0;
                    np = sv;
                    nr = !sv;
                    if (!sv) begin
                        m_hold = 0;
                        m_done = 1'b0;
                    end
                end
            end else m_run = 0;
            m_pp = np;
            m_pr = nr;
            m_pl = nl;
        end
    end

    // compare the small instance against the model every cycle
    always @(negedge clk) begin
        chk("model level", int'(s_lvl), int'(e_lvl));
        chk("model press", int'(s_pp), int'(e_press));
        chk("model release", int'(s_rp), int'(e_rel));
        chk("model long", int'(s_lp), int'(e_long));
        chk("model mode", int'(s_mode), int'(e_mode));
    end

    // small instance: NUM_MODES=5 wrap, then randomized bouncing with occasional resets
    initial begin
        repeat (3) @(negedge clk);
        sreset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sbtn = 1'b1;
            repeat (12) @(negedge clk);
            chk($sformatf("wrap5 mode %0d", i), int'(s_mode), (i + 1) % SN);
            sbtn = 1'b0;
            repeat (12) @(negedge clk);
        end
        for (int r = 0; r < 400; r++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60)) : int'($urandom_range(1, 8));
            sbtn = ~sbtn;
            if ($urandom_range(0, 60) == 0) sreset = 1'b1;
            repeat (len) @(negedge clk);
            sreset = 1'b0;
        end
        s_done = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k, p0, r0, l0;
        vecs[0] = '{100, 300, 0, 0, 0, 0};
        vecs[1] = '{199, 300, 0, 0, 0, 0};
        vecs[2] = '{200, 300, 1, 1, 0, 1};
        vecs[3] = '{500, 400, 1, 1, 0, 2};
        vecs[4] = '{3500, 400, 1, 1, 1, 0};
        vecs[5] = '{500, 400, 1, 1, 0, 1};

        btn_sel = 1'bx;
        repeat (20) @(negedge clk);
        chk("reset level", int'(lvl), 0);
        chk("reset pulses", int'({pp, rp, lp}), 0);
        chk("reset mode", int'(mode), 0);
        reset = 1'b0;
        btn_sel = 1'b0;
        p0 = n_press; r0 = n_rel; l0 = n_long;
        repeat (1000) @(negedge clk);
        chk("idle level", int'(lvl), 0);
        chk("idle pulse count", n_press - p0 + n_rel - r0 + n_long - l0, 0);
        chk("idle mode", int'(mode), 0);

        foreach (vecs[i]) begin
            p0 = n_press; r0 = n_rel; l0 = n_long;
            hold(1'b1, vecs[i].hi);
            hold(1'b0, vecs[i].lo);
            chk($sformatf("vec%0d press", i), n_press - p0, vecs[i].press);
            chk($sformatf("vec%0d release", i), n_rel - r0, vecs[i].rel);
            chk($sformatf("vec%0d long", i), n_long - l0, vecs[i].lng);
            chk($sformatf("vec%0d mode", i), int'(mode), vecs[i].mode);
            chk($sformatf("vec%0d level", i), int'(lvl), 0);
        end

        do_reset();
        btn_sel = 1'b1;
        wait_for(0, 400, k);
        chk("press latency", k, 202);
        chk("level with press", int'(lvl), 1);
        @(negedge clk);
        chk("press width", int'(pp), 0);
        chk("mode after press", int'(mode), 1);
        hold(1'b1, 300);
        btn_sel = 1'b0;
        wait_for(1, 400, k);
        chk("release latency", k, 202);
        chk("level with release", int'(lvl), 0);
        @(negedge clk);
        chk("release width", int'(rp), 0);

        do_reset();
        p0 = n_press; r0 = n_rel; l0 = n_long;
        hold(1'b1, 40);
        hold(1'b0, 80);
        hold(1'b1, 80);
        hold(1'b0, 80);
        btn_sel = 1'b1;
        wait_for(0, 400, k);
        chk("bounce press latency", k, 202);
        hold(1'b1, 1300);
        btn_sel = 1'b0;
        wait_for(1, 400, k);
        hold(1'b0, 5);
        chk("bounce press count", n_press - p0, 1);
        chk("bounce release count", n_rel - r0, 1);
        chk("bounce long count", n_long - l0, 0);
        chk("bounce mode", int'(mode), 1);

        do_reset();
        p0 = n_press; r0 = n_rel; l0 = n_long;
        btn_sel = 1'b1;
        wait_for(0, 400, k);
        chk("long press latency", k, 202);
        @(negedge clk);
        chk("long mode after press", int'(mode), 1);
        wait_for(2, 3100, k);
        chk("long after press", k + 2, 3000);
        @(negedge clk);
        chk("long width", int'(lp), 0);
        chk("long mode cleared", int'(mode), 0);
        hold(1'b1, 700);
        btn_sel = 1'b0;
        wait_for(1, 400, k);
        hold(1'b0, 5);
        chk("long count", n_long - l0, 1);
        chk("long release count", n_rel - r0, 1);
        chk("long press count", n_press - p0, 1);

        do_reset();
        btn_sel = 1'b1;
        wait_for(0, 400, k);
        repeat (1499) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midhold reset level", int'(lvl), 0);
        chk("midhold reset pulses", int'({pp, rp, lp}), 0);
        chk("midhold reset mode", int'(mode), 0);
        reset = 1'b0;
        wait_for(0, 400, k);
        chk("post reset press latency", k, 202);
        @(negedge clk);
        chk("post reset mode", int'(mode), 1);
        btn_sel = 1'b0;
        wait_for(1, 400, k);

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            hold(1'b1, 500);
            chk($sformatf("wrap8 mode %0d", i), int'(mode), i % 8);
            hold(1'b0, 500);
        end

        wait (s_done);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/btn_mode_debouncer.md
Name: btn_mode_debouncer

Overview:
- Conditions the raw, bouncing mode push-button (btn_sel) for the seven-segment display top level.
- Synchronises and debounces the button.
- Emits one-cycle press, release and long-press pulses.
- Maintains the 3-bit display-mode selector that the downstream display FSM decodes into its 8 states.

Parameters:
- DEBOUNCE_CYCLES, 200, consecutive synchronised samples at one level required to accept a level change (2 us at 100 MHz).
- LONG_CYCLES, 3000, cycles in HELD after acceptance before long_press fires (30 us at 100 MHz).
- NUM_MODES, 8, number of modes; mode_sel wraps at NUM_MODES-1; legal range 2..8.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- btn_sel  input  1  raw asynchronous button, active-high, bouncing.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
- mode_sel  output  3  current display mode, 0..NUM_MODES-1.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high; port named reset.
- Reset: applies on any rising clk edge with reset=1.
  - Sync flops are cleared; state goes to IDLE; all counters go to 0.
  - All outputs are 0, including mode_sel=0.
  - Reset mid-operation aborts everything, with no pulse on the following cycle.
  - A button held through reset yields one press_pulse after reset deasserts, with normal latency.
- Synchroniser: 2-FF on btn_sel, producing s. X/Z on btn_sel is not propagated past reset because the flops reset to 0.
- Counter: dcnt, width clog2(DEBOUNCE_CYCLES)+1.
- FSM states and transitions:
  - IDLE (btn_level=0): s=1 -> PRESS_CHK with dcnt=1.
  - PRESS_CHK: s=0 -> IDLE, dcnt=0. s=1 with dcnt==DEBOUNCE_CYCLES-1 -> HELD, press_pulse=1 next cycle. Otherwise dcnt++.
  - HELD (btn_level=1): hcnt++ saturating. hcnt==LONG_CYCLES-1 -> long_press=1 next cycle, at most once per accepted press. s=0 -> RELEASE_CHK with dcnt=1.
  - RELEASE_CHK (btn_level stays 1): s=1 -> HELD; hcnt is preserved and continues. s=0 with dcnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 next cycle, hcnt=0.
- Latency: edge 0 is the first clk edge sampling btn_sel=1 with btn_sel stable thereafter. press_pulse and btn_level rise together in the cycle after edge DEBOUNCE_CYCLES+2. Release latency is symmetric.
- Outputs are all registered; pulses are exactly 1 cycle wide.
- Bounce rejection: any s toggle before dcnt completes restarts the check from the opposite state. A glitch shorter than DEBOUNCE_CYCLES never produces a pulse.
- mode_sel:
  - Increments on press_pulse, in the same cycle the pulse is visible +1 edge.
  - Wraps from NUM_MODES-1 to 0.
  - long_press forces mode_sel=0 on the following edge.
  - press_pulse and long_press are mutually exclusive by construction.
- hcnt saturates at LONG_CYCLES-1, so no repeat long_press and no wrap.

Test Plan (100 MHz clk, defaults):
1. Reset: reset=1 for 20 cycles with btn_sel=X -> all outputs 0; reset=0 with btn_sel=0 for 1000 cycles -> outputs remain 0.
2. Bounce then settle: btn_sel high 400 ns, low 800 ns, high 800 ns, low 800 ns, then high for 15 us, then low -> exactly one press_pulse, 202 edges after the final rising sample. mode_sel 0->1, no long_press, exactly one release_pulse.
3. Glitch: btn_sel high for 100 cycles, then low -> no press_pulse, btn_level stays 0, mode_sel unchanged.
4. Long press: btn_sel held 40 us -> press_pulse, mode_sel=1. long_press fires once 3000 cycles after press_pulse, then mode_sel=0. Release yields one release_pulse and no second long_press.
5. Wrap: 8 clean presses of 5 us high / 5 us low -> mode_sel sequence 1,2,...,7,0. NUM_MODES=5 run: 1,2,3,4,0,1,2,3.
6. Reset mid-hold: assert reset while in HELD with hcnt=1500, button still high -> outputs 0 next cycle. After reset drops, one press_pulse 202 edges later, mode_sel=1.
